conv_window_seq: RTL and testbench

CONV_WINDOW_SEQ -- requirements
Module: conv_window_seq

---
 rtl/conv_window_seq_pkg.sv | 16 +
 rtl/conv_window_seq_if.sv | 29 ++
 rtl/conv_window_seq_tap_cnt.sv | 40 ++++
 rtl/conv_window_seq.sv | 102 ++++++++++
 tb/tb_conv_window_seq.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_seq_pkg.sv
// Shared types and kernel geometry for the 3x3 convolution window sequencer.
package conv_window_seq_pkg;

    localparam int K           = 3;
    localparam int KERNEL_TAPS = 9;
    localparam int TAP_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        MAC,
        OUT,
        FIN
    } state_t;

endpackage

// File: rtl/conv_window_seq_if.sv
// Control/handshake bundle between the sequencer and its MAC datapath and writeback sink.
interface conv_window_seq_if #(parameter int ADDR_W = 8);
    import conv_window_seq_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pix_addr;
    logic [TAP_W-1:0]  wgt_addr;
    logic              mac_en;
    logic              acc_clr;
    logic              acc_last;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        input  start, out_ready,
        output busy, done, pix_addr, wgt_addr, mac_en, acc_clr, acc_last,
               out_valid, out_addr
    );

    modport slave (
        output start, out_ready,
        input  busy, done, pix_addr, wgt_addr, mac_en, acc_clr, acc_last,
               out_valid, out_addr
    );

endinterface

// File: rtl/conv_window_seq_tap_cnt.sv
// Kernel tap counter; kx/ky are tracked as their own counters so no divide is needed.
module conv_tap_cnt
    import conv_window_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [TAP_W-1:0] tap,
    output logic [1:0]       kx,
    output logic [1:0]       ky,
    output logic             last
);

    assign last = (tap == TAP_W'(KERNEL_TAPS - 1));

    // Wraps to zero after the last tap so the counter idles at 0 between windows.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tap <= '0;
            kx  <= '0;
            ky  <= '0;
        end else if (enable) begin
            if (last) begin
                tap <= '0;
                kx  <= '0;
                ky  <= '0;
            end else begin
                tap <= tap + 1'b1;
                if (kx == 2'(K - 1)) begin
                    kx <= '0;
                    ky <= ky + 1'b1;
                end else begin
                    kx <= kx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_seq.sv
// Walks every valid 3x3 window of an IMG_W x IMG_H frame, issuing one MAC strobe per tap.
module conv_window_seq
    import conv_window_seq_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    conv_window_seq_if.master bus
);

    localparam logic [ADDR_W-1:0] OCOL_MAX = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] OROW_MAX = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] IN_W     = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] OUT_W    = ADDR_W'(IMG_W - 2);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] orow, ocol, orow_nxt, ocol_nxt;
    logic [TAP_W-1:0]  tap;
    logic [1:0]        kx, ky;
    logic              tap_last;
    logic [ADDR_W-1:0] row_idx;

    conv_tap_cnt u_tap_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == CLR),
        .enable (state == MAC),
        .tap    (tap),
        .kx     (kx),
        .ky     (ky),
        .last   (tap_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            orow  <= '0;
            ocol  <= '0;
        end else begin
            state <= state_nxt;
            orow  <= orow_nxt;
            ocol  <= ocol_nxt;
        end
    end

    // Window position only advances on an accepted result, so a stalled sink freezes out_addr.
    always_comb begin
        state_nxt = state;
        orow_nxt  = orow;
        ocol_nxt  = ocol;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = CLR;
                    orow_nxt  = '0;
                    ocol_nxt  = '0;
                end
            end
            CLR: state_nxt = MAC;
            MAC: begin
                if (tap_last) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    if (ocol < OCOL_MAX) begin
                        ocol_nxt  = ocol + 1'b1;
                        state_nxt = CLR;
                    end else begin
                        ocol_nxt = '0;
                        if (orow < OROW_MAX) begin
                            orow_nxt  = orow + 1'b1;
                            state_nxt = CLR;
                        end else begin
                            state_nxt = FIN;
                        end
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign row_idx = orow + ADDR_W'(ky);

    // Addresses are forced to zero outside their own phase so idle outputs read as reset values.
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.acc_clr   = (state == CLR);
    assign bus.mac_en    = (state == MAC);
    assign bus.acc_last  = (state == MAC) && tap_last;
    assign bus.out_valid = (state == OUT);
    assign bus.wgt_addr  = (state == MAC) ? tap : '0;
    assign bus.pix_addr  = (state == MAC) ? (row_idx * IN_W + ocol + ADDR_W'(kx)) : '0;
    assign bus.out_addr  = (state == OUT) ? (orow * OUT_W + ocol) : '0;

endmodule

// File: tb/tb_conv_window_seq.sv
// Directed bench: a 4x4 instance for cycle-exact checks and a default 8x8 instance for frame totals.
module tb_conv_window_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    conv_window_seq_if #(.ADDR_W(8)) a_if ();
    conv_window_seq_if #(.ADDR_W(8)) b_if ();

    conv_window_seq #(.IMG_W(4), .IMG_H(4), .ADDR_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    conv_window_seq dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (a_if.busy !== 1'b0 || b_if.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %b/%b expected 0/0", a_if.busy, b_if.busy);
        end
        checks++;
        if ({a_if.done, a_if.mac_en, a_if.acc_clr, a_if.acc_last, a_if.out_valid,
             a_if.pix_addr, a_if.wgt_addr, a_if.out_addr} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got pix=%0d wgt=%0d out=%0d mac=%b clr=%b expected all 0",
                     a_if.pix_addr, a_if.wgt_addr, a_if.out_addr, a_if.mac_en, a_if.acc_clr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (a_if.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: busy got %b expected 0", a_if.busy);
        end
    endtask

    task automatic test_basic_pass();
        int exp_pix[9]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int exp_tap0[4] = '{0, 1, 4, 5};
        int exp_tap8[4] = '{10, 11, 14, 15};
        int hs_addr[4];
        int tap0[4];
        int tap8[4];
        int hs_n = 0, t0_n = 0, t8_n = 0, excl_err = 0, done_cyc = -1;
        a_if.out_ready = 1'b1;
        a_if.start     = 1'b1;
        tick();
        a_if.start = 1'b0;
        for (int cyc = 1; cyc < 200 && done_cyc < 0; cyc++) begin
            if (cyc == 1) begin
                checks++;
                if (a_if.acc_clr !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL first_clr: acc_clr got %b expected 1", a_if.acc_clr);
                end
            end
            if (cyc >= 2 && cyc <= 10) begin
                checks++;
                if (a_if.mac_en !== 1'b1 || a_if.pix_addr !== 8'(exp_pix[cyc-2]) ||
                    a_if.wgt_addr !== 4'(cyc - 2) || a_if.acc_last !== (cyc == 10)) begin
                    failures++;
                    $display("[TB] FAIL first_window_tap%0d: got mac=%b pix=%0d wgt=%0d last=%b expected mac=1 pix=%0d wgt=%0d",
                             cyc - 2, a_if.mac_en, a_if.pix_addr, a_if.wgt_addr, a_if.acc_last,
                             exp_pix[cyc-2], cyc - 2);
                end
            end
            if ((a_if.acc_clr & a_if.mac_en) | (a_if.acc_clr & a_if.out_valid) |
                (a_if.mac_en & a_if.out_valid)) excl_err++;
            if (a_if.out_valid === 1'b1 && hs_n < 4) hs_addr[hs_n++] = int'(a_if.out_addr);
            if (a_if.mac_en === 1'b1 && a_if.wgt_addr == 4'd0 && t0_n < 4) tap0[t0_n++] = int'(a_if.pix_addr);
            if (a_if.mac_en === 1'b1 && a_if.wgt_addr == 4'd8 && t8_n < 4) tap8[t8_n++] = int'(a_if.pix_addr);
            if (a_if.done === 1'b1) done_cyc = cyc;
            tick();
        end
        checks++;
        if (done_cyc != 45) begin
            failures++;
            $display("[TB] FAIL done_cycle: got %0d expected 45", done_cyc);
        end
        checks++;
        if (hs_n != 4 || t0_n != 4 || t8_n != 4) begin
            failures++;
            $display("[TB] FAIL window_count: got hs=%0d tap0=%0d tap8=%0d expected 4/4/4", hs_n, t0_n, t8_n);
        end
        for (int i = 0; i < 4 && i < hs_n && i < t0_n && i < t8_n; i++) begin
            checks++;
            if (hs_addr[i] != i || tap0[i] != exp_tap0[i] || tap8[i] != exp_tap8[i]) begin
                failures++;
                $display("[TB] FAIL window%0d: got out=%0d tap0=%0d tap8=%0d expected out=%0d tap0=%0d tap8=%0d",
                         i, hs_addr[i], tap0[i], tap8[i], i, exp_tap0[i], exp_tap8[i]);
            end
        end
        checks++;
        if (excl_err != 0) begin
            failures++;
            $display("[TB] FAIL strobe_exclusive: got %0d overlapping cycles expected 0", excl_err);
        end
        checks++;
        if (a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_fin: got busy=%b done=%b expected 0/0", a_if.busy, a_if.done);
        end
    endtask

    task automatic test_stall();
        int done_cyc = -1, stall_err = 0;
        a_if.out_ready = 1'b0;
        a_if.start     = 1'b1;
        tick();
        a_if.start = 1'b0;
        for (int cyc = 1; cyc < 200 && done_cyc < 0; cyc++) begin
            a_if.out_ready = (cyc >= 16);
            if (cyc >= 11 && cyc <= 16) begin
                if (a_if.out_valid !== 1'b1 || a_if.out_addr !== 8'd0 || a_if.mac_en !== 1'b0) stall_err++;
            end
            if (cyc == 17) begin
                checks++;
                if (a_if.acc_clr !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL stall_resume: acc_clr got %b expected 1", a_if.acc_clr);
                end
            end
            if (a_if.done === 1'b1) done_cyc = cyc;
            tick();
        end
        checks++;
        if (stall_err != 0) begin
            failures++;
            $display("[TB] FAIL stall_hold: got %0d bad OUT cycles expected 0", stall_err);
        end
        checks++;
        if (done_cyc != 50) begin
            failures++;
            $display("[TB] FAIL stall_done_cycle: got %0d expected 50", done_cyc);
        end
        a_if.out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_window();
        a_if.out_ready = 1'b1;
        a_if.start     = 1'b1;
        tick();
        a_if.start = 1'b0;
        for (int cyc = 1; cyc < 17; cyc++) tick();
        checks++;
        if (a_if.mac_en !== 1'b1 || a_if.wgt_addr !== 4'd4 || a_if.pix_addr !== 8'd6) begin
            failures++;
            $display("[TB] FAIL win2_tap4: got mac=%b wgt=%0d pix=%0d expected 1/4/6",
                     a_if.mac_en, a_if.wgt_addr, a_if.pix_addr);
        end
        rst        = 1'b1;
        a_if.start = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({a_if.busy, a_if.done, a_if.mac_en, a_if.acc_clr, a_if.acc_last, a_if.out_valid,
             a_if.pix_addr, a_if.wgt_addr, a_if.out_addr} !== '0) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs: got busy=%b mac=%b clr=%b pix=%0d wgt=%0d expected all 0",
                     a_if.busy, a_if.mac_en, a_if.acc_clr, a_if.pix_addr, a_if.wgt_addr);
        end
        tick();
        a_if.start = 1'b0;
        checks++;
        if (a_if.acc_clr !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_clr: acc_clr got %b expected 1", a_if.acc_clr);
        end
        tick();
        checks++;
        if (a_if.mac_en !== 1'b1 || a_if.wgt_addr !== 4'd0 || a_if.pix_addr !== 8'd0) begin
            failures++;
            $display("[TB] FAIL restart_tap0: got mac=%b wgt=%0d pix=%0d expected 1/0/0",
                     a_if.mac_en, a_if.wgt_addr, a_if.pix_addr);
        end
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (a_if.out_valid !== 1'b1 || a_if.out_addr !== 8'd0) begin
            failures++;
            $display("[TB] FAIL restart_out_addr: got valid=%b addr=%0d expected 1/0", a_if.out_valid, a_if.out_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_start_held();
        int clr_n = 0, done_cyc = -1;
        a_if.out_ready = 1'b1;
        a_if.start     = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 47; cyc++) begin
            if (cyc <= 45 && a_if.acc_clr === 1'b1) clr_n++;
            if (a_if.done === 1'b1) done_cyc = cyc;
            if (cyc == 46) begin
                checks++;
                if (a_if.busy !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL held_start_fin_ignored: busy got %b expected 0", a_if.busy);
                end
            end
            if (cyc == 47) begin
                checks++;
                if (a_if.acc_clr !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL held_start_second_pass: acc_clr got %b expected 1", a_if.acc_clr);
                end
            end
            if (cyc < 47) tick();
        end
        checks++;
        if (clr_n != 4 || done_cyc != 45) begin
            failures++;
            $display("[TB] FAIL held_start_single_pass: got clr=%0d done=%0d expected 4/45", clr_n, done_cyc);
        end
        a_if.start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        int hs_n = 0, mac_n = 0, last_n = 0, done_n = 0, done_cyc = -1, last_addr = -1;
        b_if.out_ready = 1'b1;
        b_if.start     = 1'b1;
        tick();
        b_if.start = 1'b0;
        for (int cyc = 1; cyc < 600 && b_if.busy === 1'b1; cyc++) begin
            if (b_if.out_valid === 1'b1) begin
                hs_n++;
                last_addr = int'(b_if.out_addr);
            end
            if (b_if.mac_en === 1'b1) mac_n++;
            if (b_if.acc_last === 1'b1) last_n++;
            if (b_if.done === 1'b1) begin
                done_n++;
                done_cyc = cyc;
            end
            tick();
        end
        checks++;
        if (hs_n != 36 || last_addr != 35) begin
            failures++;
            $display("[TB] FAIL frame_outputs: got hs=%0d last_addr=%0d expected 36/35", hs_n, last_addr);
        end
        checks++;
        if (mac_n != 324 || last_n != 36) begin
            failures++;
            $display("[TB] FAIL frame_macs: got mac=%0d last=%0d expected 324/36", mac_n, last_n);
        end
        checks++;
        if (done_n != 1 || done_cyc != 397) begin
            failures++;
            $display("[TB] FAIL frame_done: got count=%0d cycle=%0d expected 1/397", done_n, done_cyc);
        end
    endtask

    initial begin
        rst            = 1'b1;
        a_if.start     = 1'b0;
        a_if.out_ready = 1'b1;
        b_if.start     = 1'b0;
        b_if.out_ready = 1'b1;
        tick();
        tick();
        test_reset();
        test_basic_pass();
        test_stall();
        test_reset_mid_window();
        test_start_held();
        test_full_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
